dl_shift_serial: RTL and testbench
==================================

Name: dl_shift_serial

Overview:
- Area-optimised iterative shift unit for the RISC-V execute stage.
- Performs SLL, SRL and SRA by shifting one bit position per clock.
- Sits between the issue stage and the writeback mux with valid/ready handshakes on both sides.
- Used in place of the combinational barrel shifter in the small-core configuration.

Parameters:
- NUM_BITS, 32, operand/result width; power of two, >= 2.
- NUM_SHIFT_BITS, $clog2(NUM_BITS), width of the shift-amount input.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_val  input  1  request valid.
- in_rdy  output  1  unit can accept a request.
- op  input  2  shift_op_t: SLL=2'b00, SRL=2'b01, SRA=2'b10, PASS=2'b11 (reserved, result = operand).
- in  input  NUM_BITS  operand.
- shift  input  NUM_SHIFT_BITS  shift amount, unsigned.
- out_val  output  1  result valid.
- out_rdy  input  1  consumer accepts result.
- out  output  NUM_BITS  result.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- All outputs and state are registered. There is no combinational path from any input to out/out_val/busy. in_rdy depends only on state.
- Reset, asynchronous on rst high:
  - state=IDLE, data reg=0, count=0, op reg=SLL.
  - out=0, out_val=0, busy=0, in_rdy=1.
  - This holds even mid-operation; the in-flight request is discarded.
- FSM states IDLE, SHIFT, DONE:
  - IDLE: in_rdy=1. On in_val&&in_rdy, capture in, op and shift.
    - shift==0 or op==PASS: go to DONE.
    - Otherwise: go to SHIFT with count=shift.
  - SHIFT: each cycle, data shifted one position and count decremented.
    - SLL: zero fill on the LSB side.
    - SRL: zero fill on the MSB side.
    - SRA: the MSB is replicated.
    - When count==1, the final step occurs and the FSM goes to DONE.
    - in_rdy=0. Inputs are ignored.
  - DONE: out_val=1 and out=data reg. out is held stable while out_rdy=0. On out_rdy, go to IDLE.
    - No same-cycle accept of a new request; in_rdy rises the cycle after the output handshake.
- Latency: a request accepted in cycle T has out_val high in cycle T+1+S, where S = shift amount (0 for PASS).
  - Maximum latency is NUM_BITS cycles (S = NUM_BITS-1).
  - Throughput: one result per S+2 cycles with out_rdy held high.
- Width rules: shift is interpreted modulo NUM_BITS, since it is natively NUM_SHIFT_BITS wide. The result is exactly NUM_BITS; bits shifted out are discarded.
- out_val in IDLE/SHIFT is 0; out then holds the last computed value and is don't-care for consumers.
- in_val may drop without ready; no request is latched unless in_val&&in_rdy on the same edge.

Decomposition:
- Package dl_shift_pkg holds:
  - typedef enum logic [1:0] shift_op_t {SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_PASS}.
  - typedef enum logic [1:0] shift_state_t {ST_IDLE, ST_SHIFT, ST_DONE}.
  - This package is shared with the barrel-shifter decode.
- One sub-module: dl_shift_step.
  - Parameter NUM_BITS. Purely combinational one-position shift.
  - Inputs: data, op. Output: data shifted by 1 per op. PASS returns the data unchanged.
  - The top level holds the FSM, counter, data/op registers and handshake logic.

Test Plan (NUM_BITS=8):
- SRA, in=8'h80, shift=3, out_rdy=1 -> out_val at T+4, out=8'hF0; in_rdy returns the cycle after the handshake.
- SRL, in=8'h80, shift=7 -> out=8'h01 at T+8. SLL, in=8'h81, shift=1 -> out=8'h02 at T+2.
- shift=0 with SRA, in=8'hA5, and also op=PASS with shift=5 -> out=8'hA5 at T+1 in both cases.
- Backpressure: SLL 8'h0F by 4, out_rdy low for 5 cycles after out_val.
  - out=8'hF0 stays stable and out_val stays high; in_rdy=0 and busy=1 throughout.
  - Handshake on the 6th cycle; in_rdy=1 on the next cycle.
- Reset mid-SHIFT: SRL 8'hFF by 6, assert rst asynchronously after 2 shift cycles.
  - Outputs immediately go to out=0, out_val=0, busy=0, in_rdy=1.
  - After rst deasserts, a new SLL 8'h01 by 2 yields 8'h04 at T+3.
- Back-to-back random ops/amounts with in_val held high and random out_rdy, 500 requests.
  - Scoreboard against a reference computed in the bench with >>> / >> / <<.
  - Results are in order with no drops or duplicates.

Source files
------------

// File: rtl/dl_shift_pkg.sv
// Shared shift-unit encodings: operation codes and iterative-shifter FSM states.
package dl_shift_pkg;

   typedef enum logic [1:0] {
      SHIFT_SLL  = 2'b00,
      SHIFT_SRL  = 2'b01,
      SHIFT_SRA  = 2'b10,
      SHIFT_PASS = 2'b11
   } shift_op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } shift_state_t;

endpackage

// File: rtl/dl_shift_step.sv
// Combinational single-position shift: SLL/SRL zero fill, SRA replicates the MSB, PASS is identity.
module dl_shift_step
   import dl_shift_pkg::*;
#(
   parameter int unsigned NUM_BITS = 32
) (
   input  logic [NUM_BITS-1:0] data,
   input  shift_op_t           op,
   output logic [NUM_BITS-1:0] result
);

   always_comb begin
      result = data;
      case (op)
         SHIFT_SLL: result = {data[NUM_BITS-2:0], 1'b0};
         SHIFT_SRL: result = {1'b0, data[NUM_BITS-1:1]};
         SHIFT_SRA: result = {data[NUM_BITS-1], data[NUM_BITS-1:1]};
         default:   result = data;
      endcase
   end

endmodule

// File: rtl/dl_shift_serial.sv
// Iterative shifter: one bit position per clock, valid/ready on request and result sides.
module dl_shift_serial
   import dl_shift_pkg::*;
#(
   parameter int unsigned NUM_BITS       = 32,
   parameter int unsigned NUM_SHIFT_BITS = $clog2(NUM_BITS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_val,
   output logic                      in_rdy,
   input  logic [1:0]                op,
   input  logic [NUM_BITS-1:0]       in,
   input  logic [NUM_SHIFT_BITS-1:0] shift,
   output logic                      out_val,
   input  logic                      out_rdy,
   output logic [NUM_BITS-1:0]       out,
   output logic                      busy
);

   shift_state_t              state, state_next;
   shift_op_t                 op_r, op_next;
   logic [NUM_BITS-1:0]       data, data_next, step_data;
   logic [NUM_SHIFT_BITS-1:0] count, count_next;

   dl_shift_step #(.NUM_BITS(NUM_BITS)) u_step (
      .data   (data),
      .op     (op_r),
      .result (step_data)
   );

   always_comb begin
      state_next = state;
      op_next    = op_r;
      data_next  = data;
      count_next = count;
      case (state)
         ST_IDLE: begin
            if (in_val && in_rdy) begin
               data_next  = in;
               op_next    = shift_op_t'(op);
               count_next = shift;
               if (shift == '0 || shift_op_t'(op) == SHIFT_PASS)
                  state_next = ST_DONE;
               else
                  state_next = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            data_next  = step_data;
            count_next = count - NUM_SHIFT_BITS'(1);
            if (count == NUM_SHIFT_BITS'(1))
               state_next = ST_DONE;
         end
         ST_DONE: begin
            if (out_rdy)
               state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Status outputs are flopped from the next state so they stay pure register outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         op_r    <= SHIFT_SLL;
         data    <= '0;
         count   <= '0;
         in_rdy  <= 1'b1;
         out_val <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state   <= state_next;
         op_r    <= op_next;
         data    <= data_next;
         count   <= count_next;
         in_rdy  <= (state_next == ST_IDLE);
         out_val <= (state_next == ST_DONE);
         busy    <= (state_next != ST_IDLE);
      end
   end

   assign out = data;

endmodule

// File: tb/tb_dl_shift_serial.sv
// Directed and randomized checks of dl_shift_serial (NUM_BITS=8) against a arithmetic reference.
module tb_dl_shift_serial;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_val;
   logic       in_rdy;
   logic [1:0] op;
   logic [7:0] din;
   logic [2:0] sh;
   logic       out_val;
   logic       out_rdy;
   logic [7:0] dout;
   logic       busy;

   int tests = 0;
   int fails = 0;

   dl_shift_serial #(.NUM_BITS(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .in_val  (in_val),
      .in_rdy  (in_rdy),
      .op      (op),
      .in      (din),
      .shift   (sh),
      .out_val (out_val),
      .out_rdy (out_rdy),
      .out     (dout),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] ref_shift(input logic [1:0] o, input logic [7:0] d,
                                            input logic [2:0] s);
      case (o)
         2'd0:    return d << s;
         2'd1:    return d >> s;
         2'd2:    return 8'($signed(d) >>> s);
         default: return d;
      endcase
   endfunction

   // One request with out_rdy high; checks latency, result and in_rdy after the handshake.
   task automatic do_req(input string tag, input logic [1:0] o, input logic [7:0] d,
                         input logic [2:0] s, input logic [7:0] exp, input int lat);
      int n;
      check({tag, " in_rdy_before"}, in_rdy, 1);
      in_val = 1'b1; op = o; din = d; sh = s; out_rdy = 1'b1;
      tick();
      in_val = 1'b0; op = 2'($urandom); din = 8'($urandom); sh = 3'($urandom);
      n = 1;
      while (!out_val && n < 20) begin
         tick();
         n++;
      end
      check({tag, " latency"}, n, lat);
      check({tag, " out"}, dout, exp);
      check({tag, " in_rdy_done"}, in_rdy, 0);
      tick();
      check({tag, " in_rdy_after"}, in_rdy, 1);
      check({tag, " out_val_after"}, out_val, 0);
   endtask

   initial begin
      logic [7:0] exp_q[$];
      logic [7:0] r_in;
      logic [1:0] r_op;
      logic [2:0] r_sh;
      logic       acc, hs;
      int         sent, recv, cyc, n;

      rst = 1'b1; in_val = 1'b0; out_rdy = 1'b0; op = '0; din = '0; sh = '0;
      tick();
      check("reset out", dout, 0);
      check("reset out_val", out_val, 0);
      check("reset busy", busy, 0);
      check("reset in_rdy", in_rdy, 1);
      rst = 1'b0;
      tick();

      do_req("sra_80_3", 2'd2, 8'h80, 3'd3, 8'hF0, 4);
      do_req("srl_80_7", 2'd1, 8'h80, 3'd7, 8'h01, 8);
      do_req("sll_81_1", 2'd0, 8'h81, 3'd1, 8'h02, 2);
      do_req("sra_a5_0", 2'd2, 8'hA5, 3'd0, 8'hA5, 1);
      do_req("pass_a5_5", 2'd3, 8'hA5, 3'd5, 8'hA5, 1);

      // Backpressure: result held for 5 cycles, accepted on the 6th.
      in_val = 1'b1; op = 2'd0; din = 8'h0F; sh = 3'd4; out_rdy = 1'b0;
      tick();
      in_val = 1'b0;
      n = 1;
      while (!out_val && n < 20) begin
         tick();
         n++;
      end
      check("bp latency", n, 5);
      for (int i = 0; i < 5; i++) begin
         check("bp out", dout, 8'hF0);
         check("bp out_val", out_val, 1);
         check("bp in_rdy", in_rdy, 0);
         check("bp busy", busy, 1);
         tick();
      end
      check("bp out_6th", dout, 8'hF0);
      check("bp out_val_6th", out_val, 1);
      out_rdy = 1'b1;
      tick();
      check("bp in_rdy_after", in_rdy, 1);
      check("bp out_val_after", out_val, 0);

      // Asynchronous reset after two shift cycles.
      in_val = 1'b1; op = 2'd1; din = 8'hFF; sh = 3'd6;
      tick();
      in_val = 1'b0;
      tick();
      tick();
      check("rst busy_before", busy, 1);
      #2 rst = 1'b1;
      #1;
      check("rst out", dout, 0);
      check("rst out_val", out_val, 0);
      check("rst busy", busy, 0);
      check("rst in_rdy", in_rdy, 1);
      tick();
      rst = 1'b0;
      tick();
      do_req("post_rst_sll", 2'd0, 8'h01, 3'd2, 8'h04, 3);

      // Random back-to-back traffic with random backpressure.
      sent = 0; recv = 0; cyc = 0;
      r_op = 2'($urandom); r_in = 8'($urandom); r_sh = 3'($urandom);
      while (recv < 500 && cyc < 40000) begin
         in_val  = (sent < 500);
         op      = r_op; din = r_in; sh = r_sh;
         out_rdy = ($urandom_range(3) != 0);
         acc = in_val && in_rdy;
         hs  = out_val && out_rdy;
         if (hs) begin
            check("rand queue_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0)
               check("rand out", dout, exp_q.pop_front());
            recv++;
         end
         if (acc) begin
            exp_q.push_back(ref_shift(r_op, r_in, r_sh));
            sent++;
         end
         tick();
         cyc++;
         if (acc) begin
            r_op = 2'($urandom); r_in = 8'($urandom); r_sh = 3'($urandom);
         end
      end
      in_val = 1'b0;
      check("rand received", recv, 500);
      check("rand queue_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
